// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state encoding, parity modes and parity helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} uart_tx_state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_ODD) ? ~^d : ^d;
    endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on each rising edge of a clk-synchronous level
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic r_prev;
    // history starts high so a level already high at reset release is not an edge
    always_ff @(posedge clk) begin
        r_prev <= rst ? 1'b1 : in;
    end
    assign rise = in & ~r_prev;
endmodule

// File: rtl/uart_tx_tick.sv
// uart_tx_tick: valid/ready byte in, start/data/parity/stop frame out, paced by divider ticks
import uart_pkg::*;
module uart_tx_tick #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_sq,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_D = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_S = CW'(STOP_BITS - 1);
    uart_tx_state_t       r_state, w_state;
    logic [DATA_BITS-1:0] r_shift, w_shift;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic                 r_par, w_par;
    logic                 w_tick, w_accept;
    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (baud_sq),
        .rise (w_tick)
    );
    assign w_accept = tx_valid & tx_ready;
    // frame sequencing: every move past IDLE waits for a bit tick
    always_comb begin
        w_state = r_state;
        w_shift = r_shift;
        w_cnt   = r_cnt;
        w_par   = r_par;
        case (r_state)
            IDLE: if (w_accept) begin
                w_state = ARM;
                w_shift = tx_data;
                w_par   = parity_bit(8'(tx_data), PARITY);
            end
            ARM: if (w_tick) w_state = START;
            START: if (w_tick) begin
                w_state = DATA;
                w_cnt   = '0;
            end
            DATA: if (w_tick) begin
                w_shift = r_shift >> 1;
                w_state = (r_cnt != LAST_D) ? DATA : (PARITY != PAR_NONE) ? PAR : STOP;
                w_cnt   = (r_cnt == LAST_D) ? '0 : r_cnt + 1'b1;
            end
            PAR: if (w_tick) begin
                w_state = STOP;
                w_cnt   = '0;
            end
            STOP: if (w_tick) begin
                w_state = (r_cnt == LAST_S) ? IDLE : STOP;
                w_cnt   = (r_cnt == LAST_S) ? '0 : r_cnt + 1'b1;
            end
            default: w_state = IDLE;
        endcase
    end
    // state plus registered outputs decoded from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_par    <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_shift  <= w_shift;
            r_cnt    <= w_cnt;
            r_par    <= w_par;
            tx       <= (w_state == START) ? 1'b0 : (w_state == DATA) ? w_shift[0] : (w_state == PAR) ? w_par : 1'b1;
            tx_ready <= (w_state == IDLE);
            busy     <= (w_state != IDLE);
            done     <= (r_state == STOP) && (w_state == IDLE);
        end
    end
endmodule

// File: doc/uart_tx_tick.md
Name: uart_tx_tick

Overview:
- Serial UART transmitter; consumes the square-wave output of the team's modulo-N clock divider as its baud reference.
- Rising-edge detects the divider output to form a one-cycle bit tick in the clk domain.
- Frames a parallel byte as start / data (LSB first) / optional parity / stop bits on tx.
- Parallel side is a valid/ready handshake, so the core or an MMIO register can push bytes.

Parameters:
- DATA_BITS, 8, data bits per frame; legal values 5..8.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- baud_sq  input  1  divider output square wave, synchronous to clk; each rising edge is one bit period.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept; high only in IDLE.
- tx  output  1  serial line; idle high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset values: tx=1, tx_ready=1 (IDLE), busy=0, done=0, shift register=0, bit counter=0, edge-detect history=1.
- The history reset value of 1 suppresses a spurious tick when baud_sq is already high at reset release.
- Tick definition: tick = baud_sq & ~baud_sq_prev, where baud_sq_prev is registered every clk.
- States: IDLE, ARM, START, DATA, PAR, STOP. All outputs are registered.
- IDLE:
  - tx=1.
  - Accept when tx_valid & tx_ready: latch tx_data, compute and latch the parity bit, go to ARM next cycle.
  - A tick in IDLE is ignored.
- ARM: tx=1; on tick go to START. ARM aligns the frame to a bit boundary.
- START: tx=0; on tick go to DATA with bit counter=0.
- DATA:
  - tx = shift[0].
  - On tick: shift right. If counter == DATA_BITS-1, go to PAR (PARITY != 0) or STOP; otherwise increment counter.
- PAR:
  - tx = latched parity bit.
  - Even parity = XOR of the data bits; odd parity = its inverse.
  - On tick go to STOP with counter=0.
- STOP:
  - tx=1.
  - On tick: if counter == STOP_BITS-1, go to IDLE and assert done for that one cycle. Otherwise increment counter.
- Bit timing: each line bit lasts exactly one tick-to-tick interval (2·M clk cycles with the divider).
- The tx transition occurs in the cycle after the tick.
- tx_valid held across a frame: the next byte is accepted on the first IDLE cycle after done. No bubble is required beyond that cycle.
- tx_data changing while busy has no effect on the frame in flight.
- baud_sq stuck (no ticks): the block stays in its current state indefinitely and tx holds its value. No timeout.
- rst mid-frame: next cycle tx=1, IDLE, done=0. The partial frame is abandoned.
- Counter width is $clog2(DATA_BITS); all comparisons are unsigned.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, ARM, START, DATA, PAR, STOP};
  - localparams PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- One natural sub-module: edge_detect (clk, rst, in, rise). It is registered and its history resets to 1. It is reusable for a future uart_rx and for GPIO.

Test Plan:
- Bench drives baud_sq with 3 cycles high / 3 low (6-cycle bit period).
- 8N1, tx_data=8'hA5:
  - tx sequence per bit period is 0,1,0,1,0,0,1,0,1,1.
  - done pulses once, 1 cycle after the stop-bit tick.
  - busy is high from the cycle after accept until done.
- PARITY=1, 0xA5: parity bit = 0. PARITY=2, 0xA5: parity bit = 1. PARITY=1, 0x07: parity bit = 1.
- STOP_BITS=2, 0x00: the line stays high for 2 bit periods after the data bits. done only after the second stop tick.
- Back-to-back:
  - Hold tx_valid with 0x11 then 0x22.
  - Second accept occurs the cycle after done.
  - The second start bit begins at the first tick after that.
  - Total line output equals two correct frames.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF. Next cycle tx=1, tx_ready=1, busy=0. A fresh 0x3C then transmits correctly.
- Reset release with baud_sq already high: no tick is generated. A byte accepted immediately waits in ARM until the first true rising edge.
